// File: rtl/proc_elem.sv
// Weight-stationary MAC processing element for a systolic array.
// Holds one weight, forwards activation/sum/weight to neighbours, result registered.
module proc_elem #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     in_val,
  input  logic [3*WIDTH-1:0]   in_sum,
  input  logic [WIDTH-1:0]     in_weight,
  output logic [WIDTH-1:0]     out_val,
  output logic [3*WIDTH-1:0]   out_sum,
  output logic [WIDTH-1:0]     out_weight
);

  logic [WIDTH-1:0]   weight_q, weight_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [3*WIDTH-1:0] sum_q, sum_d;
  logic [2*WIDTH-1:0] prod;
  logic [3*WIDTH-1:0] mac;

  // Operands widened first so the product keeps all 2*WIDTH bits; the add wraps.
  assign prod = {{WIDTH{1'b0}}, in_val} * {{WIDTH{1'b0}}, weight_q};
  assign mac  = in_sum + {{WIDTH{1'b0}}, prod};

  always_comb begin
    weight_d = weight_q;
    val_d    = in_val;
    sum_d    = mac;
    if (load) begin
      // Bubble on load so no MAC runs against a half-loaded array.
      weight_d = in_weight;
      val_d    = '0;
      sum_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      weight_q <= '0;
      val_q    <= '0;
      sum_q    <= '0;
    end else begin
      weight_q <= weight_d;
      val_q    <= val_d;
      sum_q    <= sum_d;
    end
  end

  assign out_weight = weight_q;
  assign out_val    = val_q;
  assign out_sum    = sum_q;

endmodule

// File: tb/tb_proc_elem.sv
// Directed self-checking bench for proc_elem with WIDTH=3 (9-bit sums),
// including a two-PE weight chain.
module tb_proc_elem;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           reset, load;
  logic [W-1:0]   in_val, in_weight;
  logic [3*W-1:0] in_sum;
  logic [W-1:0]   out_val0, out_weight0, out_val1, out_weight1;
  logic [3*W-1:0] out_sum0, out_sum1;
  logic [W-1:0]   in_val1;
  logic [3*W-1:0] in_sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_elem #(.WIDTH(W)) u_pe0 (
    .clk(clk), .reset(reset), .load(load),
    .in_val(in_val), .in_sum(in_sum), .in_weight(in_weight),
    .out_val(out_val0), .out_sum(out_sum0), .out_weight(out_weight0)
  );

  proc_elem #(.WIDTH(W)) u_pe1 (
    .clk(clk), .reset(reset), .load(load),
    .in_val(in_val1), .in_sum(in_sum1), .in_weight(out_weight0),
    .out_val(out_val1), .out_sum(out_sum1), .out_weight(out_weight1)
  );

  task automatic check(input string tag, input logic [3*W-1:0] obs, input logic [3*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input int v, input int s, input int w);
    @(negedge clk);
    reset     = r;
    load      = l;
    in_val    = W'(v);
    in_sum    = (3*W)'(s);
    in_weight = W'(w);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_val1 = '0;
    in_sum1 = '0;
    reset = 1'b1; load = 1'b0; in_val = 3'd5; in_sum = 9'd7; in_weight = 3'd6;

    drive(1, 0, 5, 7, 6); edge_wait(); edge_wait();
    check("rst_val", {6'd0, out_val0}, 9'd0);
    check("rst_sum", out_sum0, 9'd0);
    check("rst_weight", {6'd0, out_weight0}, 9'd0);

    drive(0, 0, 5, 7, 0); edge_wait();
    check("post_rst_sum", out_sum0, 9'd7);
    check("post_rst_val", {6'd0, out_val0}, 9'd5);

    drive(0, 1, 1, 1, 3); edge_wait();
    check("load3_weight", {6'd0, out_weight0}, 9'd3);
    check("load3_sum", out_sum0, 9'd0);
    check("load3_val", {6'd0, out_val0}, 9'd0);

    drive(0, 0, 4, 10, 0); edge_wait();
    check("mac1_sum", out_sum0, 9'd22);
    check("mac1_val", {6'd0, out_val0}, 9'd4);

    drive(0, 0, 2, 4, 0); edge_wait();
    check("mac2_sum", out_sum0, 9'd10);
    check("mac2_val", {6'd0, out_val0}, 9'd2);
    edge_wait(); edge_wait();
    check("hold_sum", out_sum0, 9'd10);
    check("hold_weight", {6'd0, out_weight0}, 9'd3);

    drive(0, 1, 2, 4, 5); edge_wait();
    check("reload_sum", out_sum0, 9'd0);
    check("reload_val", {6'd0, out_val0}, 9'd0);
    check("reload_weight", {6'd0, out_weight0}, 9'd5);
    drive(0, 0, 2, 1, 0); edge_wait();
    check("reload_mac", out_sum0, 9'd11);

    drive(0, 1, 0, 0, 7); edge_wait();
    drive(0, 0, 7, 511, 0); edge_wait();
    check("wrap_sum", out_sum0, 9'd48);
    check("wrap_val", {6'd0, out_val0}, 9'd7);

    drive(1, 1, 6, 100, 6); edge_wait();
    check("rst_prio_weight", {6'd0, out_weight0}, 9'd0);
    check("rst_prio_sum", out_sum0, 9'd0);
    drive(0, 0, 3, 9, 0); edge_wait();
    check("rst_w0_sum", out_sum0, 9'd9);

    drive(0, 1, 0, 0, 2); edge_wait();
    drive(0, 1, 0, 0, 6); edge_wait();
    check("chain_pe0", {6'd0, out_weight0}, 9'd6);
    check("chain_pe1", {6'd0, out_weight1}, 9'd2);
    drive(0, 0, 1, 0, 4); edge_wait();
    check("chain_hold_pe0", {6'd0, out_weight0}, 9'd6);
    check("chain_hold_pe1", {6'd0, out_weight1}, 9'd2);
    check("chain_mac_pe0", out_sum0, 9'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
